// File: rtl/scalar_vector_scale_if.sv
// Stream bundle for scalar_vector_scale: scalar, element and scaled-result
// handshakes plus the busy flag. The DUT connects through the slave modport.
interface scalar_vector_scale_if #(
  parameter int unsigned SIZE_ARRAY = 256,
  parameter int unsigned SIZE_INT   = 32
);
  localparam int unsigned IW = (SIZE_ARRAY > 1) ? $clog2(SIZE_ARRAY) : 1;

  logic                k_valid;
  logic                k_ready;
  logic [SIZE_INT-1:0] k_data;
  logic                x_valid;
  logic                x_ready;
  logic [SIZE_INT-1:0] x_data;
  logic                y_valid;
  logic                y_ready;
  logic [SIZE_INT-1:0] y_data;
  logic [IW-1:0]       y_index;
  logic                y_last;
  logic                busy;

  modport slave (
    input  k_valid, k_data, x_valid, x_data, y_ready,
    output k_ready, x_ready, y_valid, y_data, y_index, y_last, busy
  );

  modport master (
    output k_valid, k_data, x_valid, x_data, y_ready,
    input  k_ready, x_ready, y_valid, y_data, y_index, y_last, busy
  );
endinterface

// File: rtl/scalar_vector_scale.sv
// Streaming y[i] = k * x[i] over one latched scalar and SIZE_ARRAY elements.
// Define SCALE_SATURATE_EN to clamp overflowing products to all ones.
module scalar_vector_scale #(
  parameter int unsigned SIZE_ARRAY = 256,
  parameter int unsigned SIZE_INT   = 32
) (
  input logic                  clk,
  input logic                  rst,
  scalar_vector_scale_if.slave bus
);
  localparam int unsigned   IW       = (SIZE_ARRAY > 1) ? $clog2(SIZE_ARRAY) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE_ARRAY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [SIZE_INT-1:0] k_reg_q, k_reg_d;
  logic [SIZE_INT-1:0] y_data_q, y_data_d;
  logic [IW-1:0]       count_q, count_d;
  logic [IW-1:0]       y_index_q, y_index_d;
  logic                y_valid_q, y_valid_d;
  logic                y_last_q, y_last_d;
  logic [SIZE_INT-1:0] scaled;
  logic                k_ready, x_ready;
  logic                k_fire, x_fire, y_fire;

  // Handshake readies are gated by rst so nothing is accepted in a reset cycle.
  always_comb begin
    k_ready = !rst && (state_q == IDLE);
    x_ready = !rst && (state_q == RUN) && (!y_valid_q || bus.y_ready);
    k_fire  = bus.k_valid && k_ready;
    x_fire  = bus.x_valid && x_ready;
    y_fire  = y_valid_q && bus.y_ready;
  end

`ifdef SCALE_SATURATE_EN
  logic [2*SIZE_INT-1:0] product;
  always_comb begin
    product = {{SIZE_INT{1'b0}}, k_reg_q} * {{SIZE_INT{1'b0}}, bus.x_data};
    scaled  = (|product[2*SIZE_INT-1:SIZE_INT]) ? '1 : product[SIZE_INT-1:0];
  end
`else
  always_comb begin
    scaled = k_reg_q * bus.x_data;
  end
`endif

  always_comb begin
    state_d   = state_q;
    k_reg_d   = k_reg_q;
    count_d   = count_q;
    y_data_d  = y_data_q;
    y_index_d = y_index_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    unique case (state_q)
      IDLE: begin
        if (k_fire) begin
          k_reg_d = bus.k_data;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (y_fire) y_valid_d = 1'b0;
        if (x_fire) begin
          y_data_d  = scaled;
          y_index_d = count_q;
          y_last_d  = (count_q == LAST_IDX);
          y_valid_d = 1'b1;
          if (count_q == LAST_IDX) state_d = DRAIN;
          else                     count_d = count_q + IW'(1);
        end
      end
      DRAIN: begin
        if (y_fire) begin
          y_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_reg_q   <= '0;
      count_q   <= '0;
      y_data_q  <= '0;
      y_index_q <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_reg_q   <= k_reg_d;
      count_q   <= count_d;
      y_data_q  <= y_data_d;
      y_index_q <= y_index_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
    end
  end

  assign bus.k_ready = k_ready;
  assign bus.x_ready = x_ready;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_index = y_index_q;
  assign bus.y_last  = y_last_q;
  assign bus.busy    = !rst && (state_q != IDLE);
endmodule

// File: tb/tb_scalar_vector_scale.sv
// Scoreboard bench for scalar_vector_scale (SIZE_ARRAY=4, SIZE_INT=8).
module tb_scalar_vector_scale;
  logic       clk = 1'b0;
  logic       rst;
  logic       k_valid, x_valid, y_ready;
  logic [7:0] k_data, x_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int k_acc_cyc = 0;
  int idle_cyc = 0;
  logic done;

  typedef struct {
    logic [7:0] d;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] seen[$];
  logic [1:0] seen_idx[$];
  logic [7:0] mk;
  int         midx;

  scalar_vector_scale_if #(.SIZE_ARRAY(4), .SIZE_INT(8)) bus ();

  scalar_vector_scale #(.SIZE_ARRAY(4), .SIZE_INT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.k_valid = k_valid;
  assign bus.k_data  = k_data;
  assign bus.x_valid = x_valid;
  assign bus.x_data  = x_data;
  assign bus.y_ready = y_ready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] scale_ref(input logic [7:0] k, input logic [7:0] x);
    logic [15:0] p;
    p = {8'd0, k} * {8'd0, x};
`ifdef SCALE_SATURATE_EN
    return (p[15:8] != 8'd0) ? 8'hFF : p[7:0];
`else
    return p[7:0];
`endif
  endfunction

  // Handshakes are decided at the next rising edge; inputs are stable by the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb.delete();
      midx = 0;
    end else begin
      if (bus.k_valid && bus.k_ready) begin
        mk        = bus.k_data;
        midx      = 0;
        k_acc_cyc = cyc;
      end
      if (bus.y_valid && bus.y_ready) begin
        if (sb.size() == 0) begin
          check_eq("y_unexpected", 32'(bus.y_data), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check_eq("y_data", 32'(bus.y_data), 32'(e.d));
          check_eq("y_index", 32'(bus.y_index), 32'(e.idx));
          check_eq("y_last", 32'(bus.y_last), 32'(e.last));
        end
        seen.push_back(bus.y_data);
        seen_idx.push_back(bus.y_index);
      end
      if (bus.x_valid && bus.x_ready) begin
        e.d    = scale_ref(mk, bus.x_data);
        e.idx  = 2'(midx);
        e.last = (midx == 3);
        sb.push_back(e);
        midx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_k(input logic [7:0] k);
    k_valid = 1'b1;
    k_data  = k;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.k_ready) begin
        tick();
        k_valid = 1'b0;
        return;
      end
    end
    check_eq("k_timeout", 32'd0, 32'd1);
    k_valid = 1'b0;
  endtask

  task automatic send_x(input logic [7:0] x);
    x_valid = 1'b1;
    x_data  = x;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.x_ready) begin
        tick();
        x_valid = 1'b0;
        return;
      end
    end
    check_eq("x_timeout", 32'd0, 32'd1);
    x_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.busy) begin
        idle_cyc = cyc;
        tick();
        return;
      end
    end
    check_eq("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] rk, sy, rx;
    logic [31:0] sx;

    rst = 1'b1; k_valid = 1'b0; x_valid = 1'b0;
    k_data = '0; x_data = '0; y_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("rst_y_valid", 32'(bus.y_valid), 32'd0);
    check_eq("rst_y_data", 32'(bus.y_data), 32'd0);
    check_eq("rst_y_index", 32'(bus.y_index), 32'd0);
    check_eq("rst_y_last", 32'(bus.y_last), 32'd0);
    check_eq("rst_k_ready", 32'(bus.k_ready), 32'd0);
    check_eq("rst_x_ready", 32'(bus.x_ready), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_k_ready", 32'(bus.k_ready), 32'd1);
    check_eq("post_rst_x_ready", 32'(bus.x_ready), 32'd0);
    tick();

    // Basic streaming
    seen.delete(); seen_idx.delete();
    send_k(8'd3);
    for (int i = 1; i <= 4; i++) send_x(8'(i));
    wait_idle();
    check_eq("basic_cycles", 32'(idle_cyc - k_acc_cyc), 32'd6);
    check_eq("basic_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) check_eq("basic_y3", 32'(seen[3]), 32'd12);
    check_eq("basic_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure after the first result
    seen.delete(); seen_idx.delete();
    y_ready = 1'b0;
    fork
      begin
        send_k(8'd5);
        send_x(8'd10); send_x(8'd20); send_x(8'd30); send_x(8'd40);
      end
      begin : stall
        int n;
        n = 0;
        while (!bus.y_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check_eq("bp_first_valid", 32'(bus.y_valid), 32'd1);
        check_eq("bp_first_data", 32'(bus.y_data), 32'd50);
        repeat (2) begin
          @(negedge clk);
          check_eq("bp_hold_data", 32'(bus.y_data), 32'd50);
          check_eq("bp_hold_valid", 32'(bus.y_valid), 32'd1);
          check_eq("bp_x_ready", 32'(bus.x_ready), 32'd0);
        end
        tick();
        y_ready = 1'b1;
      end
    join
    wait_idle();
    check_eq("bp_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      check_eq("bp_y0", 32'(seen[0]), 32'd50);
      check_eq("bp_y1", 32'(seen[1]), 32'd100);
      check_eq("bp_y2", 32'(seen[2]), 32'd150);
      check_eq("bp_y3", 32'(seen[3]), 32'hC8);
    end

    // Overflow handling
    seen.delete(); seen_idx.delete();
    send_k(8'd16);
    send_x(8'd20); send_x(8'd1); send_x(8'd0); send_x(8'd15);
    wait_idle();
    send_k(8'd15);
    send_x(8'd17); send_x(8'd0); send_x(8'd1); send_x(8'd2);
    wait_idle();
    check_eq("ovf_count", 32'(seen.size()), 32'd8);
    if (seen.size() == 8) begin
`ifdef SCALE_SATURATE_EN
      check_eq("ovf_16x20", 32'(seen[0]), 32'hFF);
`else
      check_eq("ovf_16x20", 32'(seen[0]), 32'h40);
`endif
      check_eq("ovf_15x17", 32'(seen[4]), 32'hFF);
    end

    // Scalar interlock with k_valid held high
    seen.delete(); seen_idx.delete();
    k_valid = 1'b1; k_data = 8'd7;
    for (int n = 0; n < 100 && !bus.k_ready; n++) @(negedge clk);
    @(negedge clk);
    tick();
    k_data = 8'd2;
    fork
      begin
        for (int i = 1; i <= 4; i++) send_x(8'(i));
      end
      begin : interlock
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (bus.busy) begin
            check_eq("il_k_ready_low", 32'(bus.k_ready), 32'd0);
          end else begin
            check_eq("il_k_ready_rise", 32'(bus.k_ready), 32'd1);
            break;
          end
        end
      end
    join
    tick();
    k_valid = 1'b0;
    check_eq("il_first_count", 32'(seen.size()), 32'd4);
    seen.delete(); seen_idx.delete();
    for (int i = 0; i < 4; i++) send_x(8'd1);
    wait_idle();
    check_eq("il_second_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      check_eq("il_y0", 32'(seen[0]), 32'd2);
      check_eq("il_idx0", 32'(seen_idx[0]), 32'd0);
    end

    // Reset in the middle of a vector
    send_k(8'd9);
    send_x(8'd1); send_x(8'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_y_valid", 32'(bus.y_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_y_last", 32'(bus.y_last), 32'd0);
    check_eq("mid_rst_k_ready", 32'(bus.k_ready), 32'd1);
    tick();
    seen.delete(); seen_idx.delete();
    send_k(8'd4);
    for (int i = 1; i <= 4; i++) send_x(8'(i));
    wait_idle();
    check_eq("fresh_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      check_eq("fresh_idx0", 32'(seen_idx[0]), 32'd0);
      check_eq("fresh_y0", 32'(seen[0]), 32'd4);
    end

    // Random vectors under random backpressure
    done = 1'b0;
    fork
      begin
        for (int v = 0; v < 100; v++) begin
          seen.delete(); seen_idx.delete();
          rk = 8'($urandom);
          sx = 0;
          send_k(rk);
          for (int i = 0; i < 4; i++) begin
            rx = 8'($urandom);
            sx += 32'(rx);
            send_x(rx);
          end
          wait_idle();
`ifndef SCALE_SATURATE_EN
          sy = '0;
          foreach (seen[j]) sy += seen[j];
          check_eq("reduce_sum", 32'(sy), 32'(8'(32'(rk) * sx)));
`endif
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          y_ready = 1'($urandom_range(0, 1));
        end
        y_ready = 1'b1;
      end
    join
    check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
